fir_decim_buffer: RTL and testbench
===================================

Name: fir_decim_buffer

Overview:
- Sits directly downstream of the 5-tap unsigned FIR stage (coefficients 5,4,3,2,1; DC gain 15). Consumes its 32-bit per-cycle output.
- Discards the filter warm-up samples, decimates by DECIM, and rescales by a right shift that approximates the 1/15 gain.
- Buffers kept samples in a small first-word-fall-through (FWFT) FIFO.
- Presents them to the consumer over a valid/ready handshake, with a sticky overflow flag.

Parameters:
- DATA_W, 32, width of input and output samples.
- DECIM, 4, decimation factor; 1 keeps every post-warm-up sample. Legal range 1..256.
- WARMUP, 4, number of accepted input samples discarded after reset (filter delay-line depth). 0 disables warm-up.
- SHIFT, 4, logical right shift applied to kept samples (divide by 16 to approximate the 1/15 gain).
- DEPTH, 8, FIFO depth in entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  DATA_W  FIR output sample, unsigned.
- in_valid  in  1  in_data holds a new sample this cycle; the input has no backpressure.
- out_data  out  DATA_W  FIFO head sample; valid only while out_valid=1.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (rst=1 at an edge), all of the following are cleared:
  - warm-up counter, phase counter, FIFO pointers, level, overflow.
  - out_valid=0 and out_data=0.
  - Reset mid-operation flushes the FIFO contents and restarts warm-up.
- Accepted sample: in_valid=1 on an edge with rst=0. Samples with in_valid=0 are ignored; counters hold.
- Warm-up: while warm_cnt < WARMUP, each accepted sample is discarded and increments warm_cnt. warm_cnt saturates at WARMUP. The phase counter is not advanced during warm-up.
- Decimation: after warm-up, each accepted sample does two things:
  - it is kept if phase==0;
  - phase advances as phase = (phase==DECIM-1) ? 0 : phase+1.
  - The first post-warm-up sample is therefore always kept.
- Scaling: stored value = in_data >> SHIFT, zero-filled, with no rounding and the full DATA_W width retained.
- Push: a kept sample is written in the same edge it is accepted. With DEPTH=8 and 3-bit pointers (or equivalent), out_valid rises the following cycle, so latency from in_data to out_data is 1 cycle when the FIFO is empty.
- Pop: occurs when out_valid && out_ready at an edge. The head advances and out_data shows the next entry (FWFT). out_ready while empty has no effect.
- Simultaneous push and pop:
  - allowed at any level, including full: the pop frees a slot and the push is accepted;
  - level is unchanged;
  - when empty, only the push applies.
- Full without a pop: the kept sample is dropped, FIFO contents are unchanged, and overflow is set to 1 on that edge.
- Overflow clearing:
  - ovf_clr=1 clears overflow at the edge;
  - if a drop occurs on the same edge as ovf_clr, set wins and overflow=1.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full/empty are distinguished by level (or an extra pointer bit), never by pointer equality alone.
- level: updates on the same edge as push/pop and always equals the number of readable entries. Range is 0..DEPTH.
- Outputs: all outputs are registered or derived from registered state. There is no combinational path from in_* to out_*.

Test Plan:
- Reset, then in_valid=1 every cycle with in_data=16*n (n=0,1,2,…) and out_ready=1 -> samples n=0..3 discarded; out_data sequence 4,8,12,16 (=16n>>4 for n=4,8,12,16); each appears 1 cycle after its input edge; out_valid pulses once every 4 cycles.
- Same stream with in_valid toggling 1/0 -> identical output values; spacing doubles; phase does not advance on idle cycles.
- out_ready=0 throughout, 40 accepted samples of 16*n -> 9 kept (n=4..36 step 4); first 8 stored so level=8; 9th (n=36) dropped and overflow=1. Then out_ready=1 -> reads 4,8,…,32 in order, level falls to 0, out_valid=0.
- FIFO full plus push and pop on the same edge -> level stays 8, no overflow, the new sample appears after the older entries. Then assert ovf_clr with no drop -> overflow=0. Then ovf_clr coincident with a drop -> overflow=1.
- Assert rst for 1 cycle with level=5 and phase=2 -> next cycle level=0, out_valid=0, overflow=0. The next 4 accepted samples are discarded again and the 5th is kept.
- DECIM=1, WARMUP=0, SHIFT=0 build with in_data=32'hFFFF_FFFF then 32'h0000_0001 -> out_data FFFF_FFFF then 0000_0001, no truncation.

Source files
------------

// File: rtl/fir_decim_buffer_if.sv
// Stream interface for fir_decim_buffer: FIR sample input, FWFT output handshake
// and the status/control side (level, sticky overflow, overflow clear).
interface fir_decim_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    logic [DATA_W-1:0]          in_data;
    logic                       in_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       overflow;
    logic                       ovf_clr;

    modport master (
        output in_data, in_valid, out_ready, ovf_clr,
        input  out_data, out_valid, level, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready, ovf_clr,
        output out_data, out_valid, level, overflow
    );
endinterface

// File: rtl/fir_decim_buffer.sv
// Post-FIR stage: drops warm-up samples, decimates, rescales by a right shift
// and buffers the kept samples in an FWFT FIFO with a sticky overflow flag.
module fir_decim_buffer #(
    parameter int DATA_W = 32,
    parameter int DECIM  = 4,
    parameter int WARMUP = 4,
    parameter int SHIFT  = 4,
    parameter int DEPTH  = 8
) (
    input logic                clk,
    input logic                rst,
    fir_decim_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [WW-1:0] WARM_MAX  = WW'(WARMUP);
    localparam logic [PW-1:0] PHASE_MAX = PW'(DECIM - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

    logic [WW-1:0]     warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              warm_done;
    logic              keep;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        warm_cnt_d = warm_cnt_q;
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        wr_data    = bus.in_data >> SHIFT;

        // warm_cnt saturates at WARMUP, so equality marks the end of warm-up
        warm_done = (warm_cnt_q == WARM_MAX);
        if (bus.in_valid && !warm_done) begin
            warm_cnt_d = warm_cnt_q + WW'(1);
        end

        keep = bus.in_valid && warm_done && (phase_q == '0);
        if (bus.in_valid && warm_done) begin
            phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + PW'(1);
        end

        // a pop on a full FIFO frees the slot the simultaneous push needs
        pop  = (level_q != '0) && bus.out_ready;
        push = keep && ((level_q != FULL_LVL) || pop);
        drop = keep && !push;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        overflow_d = drop || (overflow_q && !bus.ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt_q <= '0;
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // storage needs no reset; the output is gated to zero whenever empty
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fir_decim_buffer.sv
// Scoreboard bench for fir_decim_buffer: directed streams push expected words,
// negedge monitors pop and compare on every output handshake.
module tb_fir_decim_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb_q  [$];
    logic [31:0] sb2_q [$];

    fir_decim_buffer_if #(.DATA_W(32), .DEPTH(8)) bus  ();
    fir_decim_buffer_if #(.DATA_W(32), .DEPTH(8)) bus2 ();

    fir_decim_buffer #(.DATA_W(32), .DECIM(4), .WARMUP(4), .SHIFT(4), .DEPTH(8))
        dut (.clk(clk), .rst(rst), .bus(bus));

    fir_decim_buffer #(.DATA_W(32), .DECIM(1), .WARMUP(0), .SHIFT(0), .DEPTH(8))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic feed(input int n);
        bus.in_data  = 32'(16 * n);
        bus.in_valid = 1'b1;
        step();
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pop", bus.out_data, 32'hDEAD_BEEF);
            end else begin
                check("sb_data", bus.out_data, sb_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus2.out_valid && bus2.out_ready) begin
            if (sb2_q.size() == 0) begin
                check("sb2_unexpected_pop", bus2.out_data, 32'hDEAD_BEEF);
            end else begin
                check("sb2_data", bus2.out_data, sb2_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.ovf_clr = 1'b0;

        // reset state
        do_reset();
        check("rst_level", 32'(bus.level), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_out_data", bus.out_data, 0);

        // continuous stream, consumer always ready
        bus.out_ready = 1'b1;
        sb_q.push_back(32'd4); sb_q.push_back(32'd8);
        sb_q.push_back(32'd12); sb_q.push_back(32'd16);
        for (int n = 0; n <= 16; n++) begin
            feed(n);
            check("stream_valid", 32'(bus.out_valid), 32'((n >= 4) && (n % 4 == 0)));
        end
        bus.in_valid = 1'b0;
        step(); step();
        check("stream_drained", 32'(sb_q.size()), 0);

        // same stream with idle cycles in between
        do_reset();
        bus.out_ready = 1'b1;
        sb_q.push_back(32'd4); sb_q.push_back(32'd8);
        sb_q.push_back(32'd12); sb_q.push_back(32'd16);
        for (int k = 0; k < 36; k++) begin
            bus.in_data  = 32'(16 * (k / 2));
            bus.in_valid = (k % 2 == 0);
            step();
            check("gap_valid", 32'(bus.out_valid),
                  32'((k % 2 == 0) && (k / 2 >= 4) && ((k / 2) % 4 == 0) && (k / 2 <= 16)));
        end
        bus.in_valid = 1'b0;
        step();
        check("gap_drained", 32'(sb_q.size()), 0);

        // fill to full with consumer stalled, then overflow
        do_reset();
        for (int v = 4; v <= 32; v += 4) sb_q.push_back(32'(v));
        for (int n = 0; n < 40; n++) begin
            feed(n);
            check("fill_overflow", 32'(bus.overflow), 32'(n >= 36));
        end
        bus.in_valid = 1'b0;
        check("fill_level", 32'(bus.level), 8);
        check("fill_out_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("drain_level", 32'(bus.level), 0);
        check("drain_out_valid", 32'(bus.out_valid), 0);
        check("drain_overflow_sticky", 32'(bus.overflow), 1);
        check("drain_sb_empty", 32'(sb_q.size()), 0);

        // full with push and pop on the same edge, then overflow clear cases
        do_reset();
        for (int v = 4; v <= 36; v += 4) sb_q.push_back(32'(v));
        for (int n = 0; n <= 35; n++) feed(n);
        check("full_level", 32'(bus.level), 8);
        bus.out_ready = 1'b1;
        feed(36);
        bus.out_ready = 1'b0;
        check("pushpop_level", 32'(bus.level), 8);
        check("pushpop_overflow", 32'(bus.overflow), 0);
        for (int n = 37; n <= 40; n++) feed(n);
        check("drop_overflow", 32'(bus.overflow), 1);
        bus.in_valid = 1'b0;
        bus.ovf_clr  = 1'b1;
        step();
        bus.ovf_clr  = 1'b0;
        check("clr_overflow", 32'(bus.overflow), 0);
        for (int n = 41; n <= 44; n++) begin
            bus.ovf_clr = (n == 44);
            feed(n);
        end
        bus.ovf_clr = 1'b0;
        check("clr_vs_drop_overflow", 32'(bus.overflow), 1);
        check("clr_vs_drop_level", 32'(bus.level), 8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("full_drain_level", 32'(bus.level), 0);
        check("full_drain_sb_empty", 32'(sb_q.size()), 0);

        // reset mid-operation flushes FIFO and restarts warm-up
        do_reset();
        for (int n = 0; n <= 21; n++) feed(n);
        check("mid_level", 32'(bus.level), 5);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_level", 32'(bus.level), 0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_overflow", 32'(bus.overflow), 0);
        check("mid_rst_out_data", bus.out_data, 0);
        bus.out_ready = 1'b1;
        sb_q.push_back(32'd104); sb_q.push_back(32'd108);
        for (int m = 0; m <= 8; m++) begin
            feed(100 + m);
            check("rewarm_valid", 32'(bus.out_valid), 32'((m == 4) || (m == 8)));
        end
        bus.in_valid = 1'b0;
        step();
        check("rewarm_sb_empty", 32'(sb_q.size()), 0);

        // DECIM=1, WARMUP=0, SHIFT=0 build: full-width pass-through
        bus2.out_ready = 1'b1;
        sb2_q.push_back(32'hFFFF_FFFF);
        bus2.in_data = 32'hFFFF_FFFF; bus2.in_valid = 1'b1;
        step();
        check("b2_first_valid", 32'(bus2.out_valid), 1);
        check("b2_first_level", 32'(bus2.level), 1);
        sb2_q.push_back(32'h0000_0001);
        bus2.in_data = 32'h0000_0001;
        step();
        check("b2_pushpop_level", 32'(bus2.level), 1);
        bus2.in_valid = 1'b0;
        step();
        check("b2_empty_level", 32'(bus2.level), 0);
        check("b2_sb_empty", 32'(sb2_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
